// File: rtl/team_07_wb_master.sv
// Wishbone classic initiator: turns one valid/ready request into one bus read or write,
// with a bus-timeout abort, and returns the outcome on a valid/ready response channel.
module team_07_wb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64,
    parameter int SEL_W   = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_adr,
    input  logic [DATA_W-1:0] req_dat,
    input  logic [SEL_W-1:0]  req_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_dat,
    output logic [1:0]        rsp_err,
    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] adr_o,
    output logic [DATA_W-1:0] dat_o,
    output logic [SEL_W-1:0]  sel_o,
    input  logic [DATA_W-1:0] dat_i,
    input  logic              ack_i,
    input  logic              err_i
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_SLV_ERR = 2'b01;
    localparam logic [1:0] RSP_TIMEOUT = 2'b10;

    // A one-bit timer is kept when the timeout is disabled so no zero-width vector exists.
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;

    state_t             state, state_d;
    logic [TMR_W-1:0]   timer, timer_d;
    logic               req_ready_d, rsp_valid_d, cyc_d, stb_d, we_d;
    logic [ADDR_W-1:0]  adr_d;
    logic [DATA_W-1:0]  dat_d, rsp_dat_d;
    logic [SEL_W-1:0]   sel_d;
    logic [1:0]         rsp_err_d;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d     = state;
        timer_d     = timer;
        cyc_d       = cyc_o;
        stb_d       = stb_o;
        we_d        = we_o;
        adr_d       = adr_o;
        dat_d       = dat_o;
        sel_d       = sel_o;
        rsp_valid_d = rsp_valid;
        rsp_dat_d   = rsp_dat;
        rsp_err_d   = rsp_err;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    adr_d   = req_adr;
                    dat_d   = req_dat;
                    sel_d   = req_sel;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    timer_d = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                // Error has priority over a simultaneous acknowledge.
                if (err_i || ack_i) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_i ? RSP_SLV_ERR : RSP_OK;
                    rsp_dat_d   = (err_i || we_o) ? '0 : dat_i;
                    state_d     = RESP;
                end else if (TIMEOUT > 0 && timer == TMR_LAST) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = RSP_TIMEOUT;
                    rsp_dat_d   = '0;
                    state_d     = RESP;
                end else if (timer != TMR_MAX) begin
                    timer_d = timer + TMR_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered ready: low while in reset and for the cycle a response is consumed.
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            timer     <= '0;
            req_ready <= 1'b0;
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            we_o      <= 1'b0;
            adr_o     <= '0;
            dat_o     <= '0;
            sel_o     <= '0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= RSP_OK;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state     <= state_d;
            timer     <= timer_d;
            req_ready <= req_ready_d;
            cyc_o     <= cyc_d;
            stb_o     <= stb_d;
            we_o      <= we_d;
            adr_o     <= adr_d;
            dat_o     <= dat_d;
            sel_o     <= sel_d;
            rsp_valid <= rsp_valid_d;
            rsp_dat   <= rsp_dat_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_team_07_wb_master.sv
// Bench for team_07_wb_master: directed and random transactions against a transaction-level
// model of cycle length and response, plus a second instance with the timeout disabled.
module tb_team_07_wb_master;

    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid = 1'b0, nt_req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_adr = '0, req_dat = '0;
    logic [3:0]  req_sel = '0;
    logic        rsp_ready = 1'b0;
    logic [31:0] dat_i = '0;
    logic        ack_i = 1'b0, err_i = 1'b0;
    logic        nt_ack_i = 1'b0, nt_err_i = 1'b0;

    logic        req_ready, rsp_valid, cyc_o, stb_o, we_o;
    logic [31:0] rsp_dat, adr_o, dat_o;
    logic [1:0]  rsp_err;
    logic [3:0]  sel_o;

    logic        nt_req_ready, nt_rsp_valid, nt_cyc_o, nt_stb_o, nt_we_o;
    logic [31:0] nt_rsp_dat, nt_adr_o, nt_dat_o;
    logic [1:0]  nt_rsp_err;
    logic [3:0]  nt_sel_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    team_07_wb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .sel_o(sel_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
    );

    team_07_wb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) u_dut_nt (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid(nt_req_valid), .req_ready(nt_req_ready), .req_we(req_we),
        .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
        .rsp_valid(nt_rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(nt_rsp_dat),
        .rsp_err(nt_rsp_err),
        .cyc_o(nt_cyc_o), .stb_o(nt_stb_o), .we_o(nt_we_o), .adr_o(nt_adr_o),
        .dat_o(nt_dat_o), .sel_o(nt_sel_o), .dat_i(dat_i), .ack_i(nt_ack_i), .err_i(nt_err_i)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // mode: 0 ack, 1 err, 2 ack+err, 3 silent slave. The slave answers in the
    // (delay+1)-th cycle that cyc_o is high.
    task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int mode, input int delay,
                          input logic [31:0] rdat, input int hold, input bit keep_valid);
        int n;
        int cyc_n;
        int exp_cyc;
        logic [1:0]  exp_err;
        logic [31:0] exp_dat;

        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        check("req_ready_wait", req_ready, 1'b1);

        req_valid = 1'b1;
        req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
        tick();
        if (!keep_valid) req_valid = 1'b0;

        cyc_n = 0;
        while (cyc_o && cyc_n < 300) begin
            cyc_n++;
            check("bus_hold", {stb_o, req_ready, we_o, adr_o, dat_o, sel_o},
                  {1'b1, 1'b0, we, adr, dat, sel});
            if (mode != 3 && cyc_n == delay + 1) begin
                ack_i = (mode != 1);
                err_i = (mode != 0);
                dat_i = rdat;
            end else begin
                dat_i = $urandom;
            end
            tick();
            ack_i = 1'b0;
            err_i = 1'b0;
        end

        if (mode == 3 || delay + 1 > TO) begin
            exp_cyc = TO;        exp_err = 2'b10; exp_dat = 32'h0;
        end else if (mode != 0) begin
            exp_cyc = delay + 1; exp_err = 2'b01; exp_dat = 32'h0;
        end else begin
            exp_cyc = delay + 1; exp_err = 2'b00; exp_dat = we ? 32'h0 : rdat;
        end

        check("cyc_len", cyc_n, exp_cyc);
        check("rsp", {rsp_valid, req_ready, cyc_o, rsp_err, rsp_dat},
              {1'b1, 1'b0, 1'b0, exp_err, exp_dat});
        for (int i = 0; i < hold; i++) begin
            tick();
            check("rsp_hold", {rsp_valid, req_ready, cyc_o, rsp_err, rsp_dat},
                  {1'b1, 1'b0, 1'b0, exp_err, exp_dat});
        end

        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("rsp_done", {rsp_valid, req_ready, cyc_o}, {1'b0, 1'b1, 1'b0});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int n;

        // Reset state of both instances.
        #12;
        check("reset_state", {cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, rsp_valid, rsp_dat,
                              rsp_err, req_ready}, 128'h0);
        check("reset_state_nt", {nt_cyc_o, nt_rsp_valid, nt_req_ready}, 3'b000);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        tick();

        // Directed cases.
        do_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, 2, 32'hAAAA_5555, 0, 1'b0);
        do_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, 0, 0, 32'h1234_5678, 0, 1'b0);
        do_txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, 3, 0, 32'h0, 0, 1'b0);
        do_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 2, 1, 32'hFFFF_FFFF, 0, 1'b0);
        do_txn(1'b0, 32'h3000_0014, 32'h0, 4'h3, 0, TO - 1, 32'hCAFE_F00D, 0, 1'b0);
        do_txn(1'b1, 32'h3000_0018, 32'h0BAD_F00D, 4'h1, 0, 1, 32'h0, 5, 1'b1);

        // Slave strobes while no cycle is open must be ignored.
        ack_i = 1'b1; err_i = 1'b1;
        tick();
        tick();
        ack_i = 1'b0; err_i = 1'b0;
        check("idle_ack_ignored", {rsp_valid, cyc_o, req_ready}, 3'b001);

        // Reset between edges while a write is on the bus.
        req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h4000_0000; req_dat = 32'h1111_2222;
        req_sel = 4'hF;
        tick();
        req_valid = 1'b0;
        tick();
        check("pre_reset_cyc", {cyc_o, stb_o}, 2'b11);
        #3 rst_i = 1'b1;
        #1;
        check("reset_mid_bus", {cyc_o, stb_o, rsp_valid, req_ready}, 4'b0000);
        tick();
        rst_i = 1'b0;
        tick();
        check("after_reset", {req_ready, rsp_valid, cyc_o}, 3'b100);
        do_txn(1'b1, 32'h4000_0004, 32'h3333_4444, 4'hC, 0, 0, 32'h0, 0, 1'b0);

        // Randomised transactions.
        for (int t = 0; t < 40; t++) begin
            int mode;
            mode = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
            do_txn(1'($urandom), $urandom, $urandom, 4'($urandom), mode,
                   int'($urandom_range(0, 20)), $urandom, int'($urandom_range(0, 3)),
                   1'($urandom));
        end

        // Timeout disabled: a silent slave keeps the cycle open indefinitely.
        n = 0;
        while (!nt_req_ready && n < 50) begin
            tick();
            n++;
        end
        check("nt_ready", nt_req_ready, 1'b1);
        nt_req_valid = 1'b1;
        tick();
        nt_req_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!nt_cyc_o || !nt_stb_o || nt_rsp_valid) bad++;
            tick();
        end
        check("nt_no_abort", bad, 0);
        check("nt_cyc_still_high", {nt_cyc_o, nt_rsp_valid}, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/team_07_wb_master.md
Name: team_07_wb_master

Overview:
Wishbone classic single-cycle-transfer initiator (master) for team_07 user logic. Converts a simple valid/ready request channel into one Wishbone read or write at a time. It drives the same bus signal set that the team_07_WB slave wrapper responds to, from the opposite end. A bus-timeout counter prevents a non-responding slave from hanging user logic. Results return on a valid/ready response channel.

Parameters:
ADDR_W, 32, width of adr_o / req_adr
DATA_W, 32, width of data buses; SEL_W = DATA_W/8
TIMEOUT, 64, cycles cyc_o may stay high without ack_i/err_i before abort; 0 disables timeout

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  asynchronous active-high reset
req_valid  in  1  user request present
req_ready  out  1  block can accept request
req_we  in  1  1 = write, 0 = read
req_adr  in  ADDR_W  byte address
req_dat  in  DATA_W  write data
req_sel  in  SEL_W  byte enables
rsp_valid  out  1  response present
rsp_ready  in  1  user accepts response
rsp_dat  out  DATA_W  read data (0 for writes and errors)
rsp_err  out  2  00 ok, 01 slave err_i, 10 timeout
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
we_o  out  1  Wishbone write enable
adr_o  out  ADDR_W  Wishbone address
dat_o  out  DATA_W  Wishbone write data
sel_o  out  SEL_W  Wishbone byte select
dat_i  in  DATA_W  Wishbone read data
ack_i  in  1  Wishbone acknowledge
err_i  in  1  Wishbone error

Behaviour:
- All outputs registered. Reset (asynchronous, immediate): state IDLE, cyc_o=stb_o=we_o=0, adr_o/dat_o/sel_o=0, rsp_valid=0, rsp_dat=0, rsp_err=00, timer=0. req_ready reads 1 only after reset is released.
- FSM states: IDLE, BUS, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready at edge N: latch we/adr/dat/sel onto bus outputs; cyc_o=stb_o=1 from cycle N+1; timer cleared; go to BUS.
- BUS: req_ready=0. All bus outputs held stable. Timer increments each cycle in which ack_i=err_i=0.
  - ack_i=1 sampled at edge M: cyc_o=stb_o=0 from M+1; rsp_dat=dat_i if read, else 0; rsp_err=00; rsp_valid=1; go to RESP.
  - err_i=1 at edge M, with or without ack_i (err wins): same as ack, but rsp_dat=0 and rsp_err=01.
  - TIMEOUT>0, no ack/err, timer==TIMEOUT-1: abort. cyc_o has then been high exactly TIMEOUT cycles. rsp_err=10, rsp_dat=0, go to RESP.
  - ack_i/err_i while cyc_o=0 are ignored.
- RESP: rsp_valid=1, with rsp_dat/rsp_err held until rsp_ready=1 at an edge. Then rsp_valid=0, go to IDLE. req_ready=0 in RESP, so no request is accepted in the same cycle the response is consumed.
- Minimum latency: request accepted at edge 0, cyc_o high in cycle 1, ack at edge 1, rsp_valid in cycle 2, earliest next req_ready in cycle 3 (rsp_ready held high).
- we_o/adr_o/dat_o/sel_o keep last values after the cycle ends; a slave must not sample them while cyc_o=0.
- Timer width clog2(TIMEOUT+1), saturating; no wrap possible.
- rst_i asserted in BUS: cyc_o/stb_o drop immediately and the transaction is abandoned with no response. rst_i asserted in RESP: pending response discarded.

Test Plan:
- Write adr 0x3000_0004, dat 0xDEADBEEF, sel 0xF; slave acks 2 cycles after stb_o rises -> cyc_o/stb_o high 3 cycles, we_o=1, adr_o/dat_o/sel_o stable throughout; then rsp_valid=1, rsp_err=00, rsp_dat=0.
- Read adr 0x3000_0008; zero-wait ack with dat_i=0x12345678 -> rsp_valid exactly 2 cycles after acceptance, rsp_dat=0x12345678, rsp_err=00.
- TIMEOUT=16, slave never responds -> cyc_o high exactly 16 cycles, then rsp_err=10, rsp_dat=0. Repeat with TIMEOUT=0 for 1000 cycles -> cyc_o stays high, no response.
- ack_i and err_i high in the same cycle on a read with dat_i=0xFFFF_FFFF -> rsp_err=01, rsp_dat=0.
- rsp_ready held low 5 cycles after response while req_valid stays high -> rsp_valid/rsp_dat stable, req_ready=0, no new cyc_o. After rsp_ready, the next request is accepted one cycle later.
- rst_i pulsed mid-BUS (between edges) -> cyc_o/stb_o low before the next clock edge, no rsp_valid; after release, req_ready=1 and a new write completes normally.
